arb_counter_bank: RTL and testbench
===================================

Name: arb_counter_bank

Overview:
- Bank of NCH independent up/down counters for per-channel credit/occupancy tracking in the 8b/10b arbitration path.
- Generalises the single arbiter counter:
  - programmable ceiling
  - saturation at both ends, with sticky overflow/underflow error reporting
  - per-channel parallel load
  - registered, glitch-free status flags
- Sits between the arbitrator and the per-channel encoder queues; the arbitrator no longer has to guard decrement-at-zero.

Parameters:
- NCH, 4, number of independent channels (>=1)
- NBITS, 4, counter width per channel (>=2)
- RESET_VAL, 0, count value every channel takes on reset/clear (must be <= 2**NBITS-1)

Ports:
- CLK  in  1  clock, rising edge
- RST  in  1  synchronous reset, active-high
- clear  in  NCH  per-channel synchronous clear to RESET_VAL
- inc  in  NCH  per-channel increment by 1
- dec  in  NCH  per-channel decrement by 1
- load  in  NCH  per-channel parallel load
- load_val  in  NCH*NBITS  load data, channel i at [i*NBITS +: NBITS]
- max_val  in  NBITS  shared programmable ceiling (quasi-static)
- err_clr  in  1  clears sticky error vectors
- count  out  NCH*NBITS  current counts, channel i at [i*NBITS +: NBITS]
- at_max  out  NCH  count >= max_val
- at_zero  out  NCH  count == 0
- err_ovf  out  NCH  sticky: increment or load attempted beyond ceiling
- err_udf  out  NCH  sticky: decrement attempted at zero

Behaviour:
- Clock and reset:
  - Single clock domain, CLK. RST is synchronous and active-high; it is sampled only on the rising edge of CLK.
  - RST asserted at an edge: all counts = RESET_VAL, err_ovf = 0, err_udf = 0.
  - at_max and at_zero are then decoded from RESET_VAL (e.g. at_zero = 1 when RESET_VAL = 0).
  - RST overrides all other inputs, including mid-operation.
- Per-channel update priority, evaluated each edge: RST > clear > load > inc/dec.
- clear: count <= RESET_VAL. No error flags change.
- load:
  - If load_val <= max_val: count <= load_val.
  - Otherwise: count <= max_val and err_ovf[i] set.
  - inc/dec are ignored in the same cycle.
- inc and dec together: count holds; no error.
- inc only:
  - count < max_val: count+1.
  - Otherwise: hold and set err_ovf[i].
  - No wrap-around ever.
- dec only:
  - count > 0: count-1.
  - count == 0: hold and set err_udf[i].
  - No wrap to all-ones.
- Neither inc nor dec: hold.
- max_val changes:
  - If max_val is lowered below a live count, the count is not altered.
  - at_max asserts (>= compare), inc saturates with err_ovf, and dec operates normally.
  - max_val = 0: only dec from a prior nonzero count moves the counter.
- Output timing:
  - count, at_max and at_zero are driven from the count register plus max_val.
  - There is no combinational path from inc/dec/load/clear to any output.
  - Latency is 1 cycle: a request at edge N is visible after edge N.
- Errors:
  - err_ovf and err_udf are registered.
  - Set in the cycle after the offending request; held until err_clr or RST.
  - err_clr and a new error in the same cycle on the same channel: error wins (bit stays 1).
  - err_clr alone: all bits 0 next cycle.
- Arithmetic: the compare for inc uses an NBITS-wide count < max_val, so no NBITS+1 overflow term is needed. Channels are fully independent.

Decomposition:
- Package arb_counter_pkg:
  - typedef count_t = logic [NBITS-1:0] (parameterised via the package default of 4)
  - enum cnt_op_e {OP_HOLD, OP_CLEAR, OP_LOAD, OP_INC, OP_DEC}, used for the decoded per-channel operation
- Sub-module arb_counter_cell:
  - one channel: count register, op decode, saturation, sticky error bits
  - instantiated NCH times by generate in arb_counter_bank
  - the top level only slices the vectors and fans out max_val/err_clr

Test Plan:
- RST=1 for 2 cycles, RESET_VAL=0, NCH=4, NBITS=4 -> all count=0, at_zero=4'hF, at_max=0 (max_val=15), err_*=0.
- Ch0 inc for 16 cycles with max_val=15 -> count reaches 15 after 15 edges, at_max[0]=1, 16th inc holds 15, err_ovf[0]=1; other channels unchanged.
- Ch1 dec at count 0 -> count stays 0, err_udf[1]=1. Then err_clr together with a second dec -> err_udf[1] remains 1. err_clr alone -> 0.
- Ch2 load load_val=12 with max_val=9 -> count=9, err_ovf[2]=1. Load 5 together with inc=1 -> count=5 (load wins).
- Ch3 at count 7: inc and dec together -> holds 7. clear together with load=3 -> count=RESET_VAL. Then lower max_val from 15 to 4 with count=7 -> at_max[3]=1, inc holds 7, dec gives 6.
- Mid-stream RST while ch0=10, ch1=3 and inc/dec active -> next cycle all counts=RESET_VAL, errors cleared; run a second build with RESET_VAL=2 -> counts=2, at_zero=0.

Source files
------------

// File: rtl/arb_counter_pkg.sv
// Shared types for the arbitration counter bank: the default count width
// and the decoded per-channel operation.
package arb_counter_pkg;

    localparam int NBITS_DEF = 4;

    typedef logic [NBITS_DEF-1:0] count_t;

    typedef enum logic [2:0] {
        OP_HOLD,
        OP_CLEAR,
        OP_LOAD,
        OP_INC,
        OP_DEC
    } cnt_op_e;

endpackage

// File: rtl/arb_counter_bank_if.sv
// Request/status bundle between the arbitrator (master) and the counter bank (slave).
interface arb_counter_bank_if #(
    parameter int NCH   = 4,
    parameter int NBITS = 4
);
    logic [NCH-1:0]       clear;
    logic [NCH-1:0]       inc;
    logic [NCH-1:0]       dec;
    logic [NCH-1:0]       load;
    logic [NCH*NBITS-1:0] load_val;
    logic [NBITS-1:0]     max_val;
    logic                 err_clr;
    logic [NCH*NBITS-1:0] count;
    logic [NCH-1:0]       at_max;
    logic [NCH-1:0]       at_zero;
    logic [NCH-1:0]       err_ovf;
    logic [NCH-1:0]       err_udf;

    modport master (
        output clear, inc, dec, load, load_val, max_val, err_clr,
        input  count, at_max, at_zero, err_ovf, err_udf
    );

    modport slave (
        input  clear, inc, dec, load, load_val, max_val, err_clr,
        output count, at_max, at_zero, err_ovf, err_udf
    );
endinterface

// File: rtl/arb_counter_cell.sv
// One channel of the counter bank: saturating up/down count register with
// programmable ceiling, parallel load and sticky overflow/underflow bits.
module arb_counter_cell
    import arb_counter_pkg::*;
#(
    parameter int NBITS     = 4,
    parameter int RESET_VAL = 0
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             clear,
    input  logic             inc,
    input  logic             dec,
    input  logic             load,
    input  logic [NBITS-1:0] load_val,
    input  logic [NBITS-1:0] max_val,
    input  logic             err_clr,
    output logic [NBITS-1:0] count,
    output logic             at_max,
    output logic             at_zero,
    output logic             err_ovf,
    output logic             err_udf
);

    localparam logic [NBITS-1:0] RST_CNT = NBITS'(RESET_VAL);

    // Loads above the ceiling are clamped to the ceiling.
    function automatic logic [NBITS-1:0] sat_ceil(input logic [NBITS-1:0] val,
                                                  input logic [NBITS-1:0] ceil);
        return (val > ceil) ? ceil : val;
    endfunction

    cnt_op_e          op;
    logic [NBITS-1:0] cnt_reg;
    logic [NBITS-1:0] cnt_nxt;
    logic             ovf_reg;
    logic             udf_reg;
    logic             ovf_set;
    logic             udf_set;

    // Decode the request priority: clear > load > inc/dec; inc with dec cancels.
    always_comb begin
        op = OP_HOLD;
        if (clear)              op = OP_CLEAR;
        else if (load)          op = OP_LOAD;
        else if (inc && !dec)   op = OP_INC;
        else if (dec && !inc)   op = OP_DEC;
    end

    // Next count with saturation at both ends and error detection.
    always_comb begin
        cnt_nxt = cnt_reg;
        ovf_set = 1'b0;
        udf_set = 1'b0;
        case (op)
            OP_CLEAR: cnt_nxt = RST_CNT;
            OP_LOAD: begin
                cnt_nxt = sat_ceil(load_val, max_val);
                ovf_set = (load_val > max_val);
            end
            OP_INC: begin
                if (cnt_reg < max_val) cnt_nxt = cnt_reg + 1'b1;
                else                   ovf_set = 1'b1;
            end
            OP_DEC: begin
                if (cnt_reg != '0) cnt_nxt = cnt_reg - 1'b1;
                else               udf_set = 1'b1;
            end
            default: cnt_nxt = cnt_reg;
        endcase
    end

    // Count and sticky error registers; a new error outranks err_clr.
    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_reg <= RST_CNT;
            ovf_reg <= 1'b0;
            udf_reg <= 1'b0;
        end else begin
            cnt_reg <= cnt_nxt;
            ovf_reg <= ovf_set | (ovf_reg & ~err_clr);
            udf_reg <= udf_set | (udf_reg & ~err_clr);
        end
    end

    assign count   = cnt_reg;
    assign at_max  = (cnt_reg >= max_val);
    assign at_zero = (cnt_reg == '0);
    assign err_ovf = ovf_reg;
    assign err_udf = udf_reg;

endmodule

// File: rtl/arb_counter_bank.sv
// Bank of NCH independent saturating credit counters; slices the bus per
// channel and fans out the shared ceiling and error clear.
module arb_counter_bank
    import arb_counter_pkg::*;
#(
    parameter int NCH       = 4,
    parameter int NBITS     = 4,
    parameter int RESET_VAL = 0
) (
    input logic              CLK,
    input logic              RST,
    arb_counter_bank_if.slave bus
);

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        arb_counter_cell #(
            .NBITS     (NBITS),
            .RESET_VAL (RESET_VAL)
        ) u_cell (
            .CLK      (CLK),
            .RST      (RST),
            .clear    (bus.clear[i]),
            .inc      (bus.inc[i]),
            .dec      (bus.dec[i]),
            .load     (bus.load[i]),
            .load_val (bus.load_val[i*NBITS +: NBITS]),
            .max_val  (bus.max_val),
            .err_clr  (bus.err_clr),
            .count    (bus.count[i*NBITS +: NBITS]),
            .at_max   (bus.at_max[i]),
            .at_zero  (bus.at_zero[i]),
            .err_ovf  (bus.err_ovf[i]),
            .err_udf  (bus.err_udf[i])
        );
    end

endmodule

// File: tb/tb_arb_counter_bank.sv
// Directed bench for arb_counter_bank: a RESET_VAL=0 instance carries the
// main sequence, a RESET_VAL=2 instance shares its inputs for reset checks.
module tb_arb_counter_bank;

    logic CLK = 1'b0;
    logic RST;

    int n_chk = 0;
    int n_err = 0;

    arb_counter_bank_if #(.NCH(4), .NBITS(4)) bus_a ();
    arb_counter_bank_if #(.NCH(4), .NBITS(4)) bus_b ();

    arb_counter_bank #(.NCH(4), .NBITS(4), .RESET_VAL(0)) dut_a (
        .CLK (CLK),
        .RST (RST),
        .bus (bus_a.slave)
    );

    arb_counter_bank #(.NCH(4), .NBITS(4), .RESET_VAL(2)) dut_b (
        .CLK (CLK),
        .RST (RST),
        .bus (bus_b.slave)
    );

    assign bus_b.clear    = bus_a.clear;
    assign bus_b.inc      = bus_a.inc;
    assign bus_b.dec      = bus_a.dec;
    assign bus_b.load     = bus_a.load;
    assign bus_b.load_val = bus_a.load_val;
    assign bus_b.max_val  = bus_a.max_val;
    assign bus_b.err_clr  = bus_a.err_clr;

    always #5 CLK = ~CLK;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [3:0] cnt_a(input int ch);
        logic [15:0] v;
        v = bus_a.count;
        return v[ch*4 +: 4];
    endfunction

    initial begin
        RST            = 1'b1;
        bus_a.clear    = '0;
        bus_a.inc      = '0;
        bus_a.dec      = '0;
        bus_a.load     = '0;
        bus_a.load_val = '0;
        bus_a.max_val  = 4'd15;
        bus_a.err_clr  = 1'b0;
        tick();
        tick();

        // reset state
        check_val("rst_count",   32'(bus_a.count),   32'h0000);
        check_val("rst_at_zero", 32'(bus_a.at_zero), 32'hF);
        check_val("rst_at_max",  32'(bus_a.at_max),  32'h0);
        check_val("rst_ovf",     32'(bus_a.err_ovf), 32'h0);
        check_val("rst_udf",     32'(bus_a.err_udf), 32'h0);
        check_val("rstb_count",  32'(bus_b.count),   32'h2222);
        check_val("rstb_zero",   32'(bus_b.at_zero), 32'h0);
        RST = 1'b0;

        // ch0 counts up to the ceiling then saturates
        bus_a.inc = 4'b0001;
        tick();
        check_val("inc_first", 32'(cnt_a(0)), 32'd1);
        repeat (14) tick();
        check_val("inc_15",      32'(cnt_a(0)),      32'd15);
        check_val("inc_at_max",  32'(bus_a.at_max),  32'b0001);
        check_val("inc_at_zero", 32'(bus_a.at_zero), 32'b1110);
        check_val("inc_no_ovf",  32'(bus_a.err_ovf), 32'h0);
        tick();
        check_val("inc_sat",     32'(bus_a.count),   32'h000F);
        check_val("inc_ovf",     32'(bus_a.err_ovf), 32'b0001);
        bus_a.inc = '0;

        // ch1 underflow, err_clr vs. new error, err_clr alone
        bus_a.dec = 4'b0010;
        tick();
        check_val("udf_cnt",  32'(cnt_a(1)),        32'd0);
        check_val("udf_set",  32'(bus_a.err_udf),   32'b0010);
        bus_a.err_clr = 1'b1;
        tick();
        check_val("udf_wins", 32'(bus_a.err_udf),   32'b0010);
        check_val("ovf_clr",  32'(bus_a.err_ovf),   32'h0);
        bus_a.dec = '0;
        tick();
        check_val("udf_clr",  32'(bus_a.err_udf),   32'h0);
        bus_a.err_clr = 1'b0;

        // ch2 load above ceiling clamps; load beats inc
        bus_a.max_val  = 4'd9;
        bus_a.load     = 4'b0100;
        bus_a.load_val = 16'h0C00;
        tick();
        check_val("ld_clamp",  32'(cnt_a(2)),       32'd9);
        check_val("ld_ovf",    32'(bus_a.err_ovf),  32'b0100);
        check_val("ld_at_max", 32'(bus_a.at_max),   32'b0101);
        bus_a.load_val = 16'h0500;
        bus_a.inc      = 4'b0100;
        tick();
        check_val("ld_wins",   32'(cnt_a(2)),       32'd5);
        check_val("ld_sticky", 32'(bus_a.err_ovf),  32'b0100);
        bus_a.load    = '0;
        bus_a.inc     = '0;
        bus_a.max_val = 4'd15;

        // ch3: inc+dec hold, clear beats load, lowered ceiling
        bus_a.load     = 4'b1000;
        bus_a.load_val = 16'h7000;
        tick();
        check_val("ch3_ld7", 32'(cnt_a(3)), 32'd7);
        bus_a.load = '0;
        bus_a.inc  = 4'b1000;
        bus_a.dec  = 4'b1000;
        tick();
        check_val("incdec_hold", 32'(cnt_a(3)),       32'd7);
        check_val("incdec_udf",  32'(bus_a.err_udf),  32'h0);
        bus_a.inc      = '0;
        bus_a.dec      = '0;
        bus_a.clear    = 4'b1000;
        bus_a.load     = 4'b1000;
        bus_a.load_val = 16'h3000;
        tick();
        check_val("clr_wins", 32'(cnt_a(3)), 32'd0);
        bus_a.clear    = '0;
        bus_a.load_val = 16'h7000;
        tick();
        bus_a.load    = '0;
        bus_a.max_val = 4'd4;
        tick();
        check_val("lowmax_cnt",   32'(cnt_a(3)),      32'd7);
        check_val("lowmax_atmax", 32'(bus_a.at_max),  32'b1101);
        bus_a.inc = 4'b1000;
        tick();
        check_val("lowmax_inc",   32'(cnt_a(3)),      32'd7);
        check_val("lowmax_ovf",   32'(bus_a.err_ovf), 32'b1100);
        bus_a.inc = '0;
        bus_a.dec = 4'b1000;
        tick();
        check_val("lowmax_dec",   32'(cnt_a(3)),      32'd6);
        bus_a.dec     = '0;
        bus_a.max_val = 4'd0;
        bus_a.inc     = 4'b0010;
        tick();
        check_val("max0_cnt",   32'(cnt_a(1)),      32'd0);
        check_val("max0_ovf",   32'(bus_a.err_ovf), 32'b1110);
        check_val("max0_atmax", 32'(bus_a.at_max),  32'hF);
        bus_a.inc = '0;

        // mid-stream reset with activity present
        bus_a.max_val  = 4'd15;
        bus_a.load     = 4'b0011;
        bus_a.load_val = 16'h003A;
        tick();
        check_val("pre_rst", 32'(bus_a.count), 32'h653A);
        bus_a.load = '0;
        bus_a.inc  = 4'b0001;
        bus_a.dec  = 4'b0010;
        RST        = 1'b1;
        tick();
        check_val("mrst_count",  32'(bus_a.count),   32'h0000);
        check_val("mrst_ovf",    32'(bus_a.err_ovf), 32'h0);
        check_val("mrst_udf",    32'(bus_a.err_udf), 32'h0);
        check_val("mrstb_count", 32'(bus_b.count),   32'h2222);
        check_val("mrstb_zero",  32'(bus_b.at_zero), 32'h0);
        check_val("mrstb_ovf",   32'(bus_b.err_ovf), 32'h0);
        RST = 1'b0;
        tick();
        check_val("post_rst_cnt", 32'(bus_a.count),   32'h0001);
        check_val("post_rst_udf", 32'(bus_a.err_udf), 32'b0010);
        check_val("postb_cnt",    32'(bus_b.count),   32'h2213);
        bus_a.inc = '0;
        bus_a.dec = '0;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
